stack_sequencer: RTL and testbench
==================================

// Module: stack_sequencer
// PURPOSE
//  Multi-byte stack access controller sitting directly upstream of the stack-pointer register.
//  Accepts one push/pull request of 0..3 bytes (PHA/PHP/PLA/PLP, JSR/RTS, BRK/RTI).
//  Issues the page-1 memory cycles for that request.
//  Drives sp_dec/sp_inc pulses into the SP register and reads the SP back on sp_cur.
//  Returns pulled bytes and a one-cycle completion strobe to the control FSM.
// PARAMETERS
//  STACK_PAGE  8'h01  high address byte of every stack access
//  MAX_BYTES   3      maximum bytes per request; data buses are 8*MAX_BYTES wide
// PORTS
//  clk         in   1    clock; all state changes on rising edge
//  reset_n     in   1    asynchronous, active-low reset
//  req_valid   in   1    request present
//  req_ready   out  1    high only in IDLE; request accepted when req_valid & req_ready
//  req_pull    in   1    1 = pull, 0 = push
//  req_len     in   2    byte count 0..MAX_BYTES
//  push_data   in   24   bytes to push; byte [8*len-1 -: 8] pushed first, [7:0] last
//  resp_valid  out  1    one-cycle done strobe
//  pull_data   out  24   first pulled byte in [7:0], then [15:8], then [23:16]
//  sp_cur      in   8    current SP (the SP register output)
//  sp_dec      out  1    decrement SP at this edge
//  sp_inc      out  1    increment SP at this edge
//  mem_req     out  1    memory cycle request, held until mem_ack
//  mem_we      out  1    1 = write (push)
//  mem_addr    out  16   {STACK_PAGE, sp_cur}
//  mem_wdata   out  8    byte being pushed
//  mem_rdata   in   8    read data, valid when mem_ack=1
//  mem_ack     in   1    cycle complete (may be high in the same cycle as mem_req)
// BEHAVIOUR
//  Reset values: state=IDLE; req_ready=1; resp_valid, sp_dec, sp_inc, mem_req and mem_we = 0;
//    mem_wdata=0; pull_data=0; mem_addr follows sp_cur.
//  Accept: latch req_pull, req_len and push_data; remaining-byte counter <= req_len.
//  States: IDLE, PUSH, PULL_INC, PULL_RD, DONE.
//  IDLE -> DONE if req_len==0: no bus cycles, no SP pulses.
//  IDLE -> PUSH on push; IDLE -> PULL_INC on pull.
//  PUSH: mem_req=1, mem_we=1, addr={PAGE,sp_cur}, wdata = next byte (high to low).
//    On mem_ack: sp_dec=1 in the same cycle, counter--, then PUSH again or DONE when the counter reaches 0.
//  PULL_INC: sp_inc=1 for exactly one cycle, then PULL_RD. The SP register updates at that edge,
//    so PULL_RD addresses the incremented SP.
//  PULL_RD: mem_req=1, mem_we=0. On mem_ack: write mem_rdata into the next pull_data byte lane
//    (lane index = bytes already pulled), counter--, then PULL_INC or DONE.
//  DONE: resp_valid=1 for one cycle -> IDLE. req_ready=0 in DONE, so back-to-back requests cost one idle cycle.
//  Wait states: mem_req, mem_we, mem_addr and mem_wdata held stable while mem_ack=0.
//    sp_dec and sp_inc are never asserted while waiting.
//  Latency with zero-wait memory: push N -> resp_valid N+1 cycles after accept; pull N -> 2N+1; len 0 -> 1.
//  Pull lanes not written by a request keep their previous value; pull_data is held until the next pull.
//  SP arithmetic is 8-bit in the SP register. Push at SP=00 writes 0x0100 and SP wraps to FF.
//    Pull at SP=FF increments to 00 and reads 0x0100. The address never leaves the stack page.
//  sp_dec and sp_inc are mutually exclusive by construction.
//  req_valid while busy is ignored and not queued.
//  mem_ack outside PUSH/PULL_RD is ignored.
//  Reset mid-request: abort immediately to IDLE and drop mem_req; a partially pushed or pulled
//    SP is not restored.
// STRUCTURE
//  Shared cpu6502 package: state encoding localparams, STACK_PAGE default, MAX_BYTES.
//  Single module: byte counter plus a byte-select mux. No sub-module is warranted; stack_unit stays separate.
//  Verification top instantiates stack_sequencer + stack_unit (SP_in=SP_out loop) + 64 KB RAM model.
// TESTING
//  1. JSR-style push len2, data 0x1234, SP=FD -> 01FD<=12, 01FC<=34, SP=FB, resp_valid at cycle 3.
//  2. RTI-style pull len3, SP=FA, RAM 01FB=20 01FC=34 01FD=12 -> pull_data=0x123420, SP=FD, resp at 7.
//  3. Wrap: push len1 data 0xAA at SP=00 -> 0100<=AA, SP=FF. Then pull len1 -> SP=00, pull_data[7:0]=AA.
//  4. Wait states: mem_ack delayed 3 cycles per byte on push len2 -> addr/wdata stable, exactly 2 sp_dec pulses.
//  5. Busy: req_valid pulsed during a pull -> ignored. len0 request -> resp in 1 cycle, no mem_req, SP unchanged.
//  6. reset_n low mid push after byte 1 -> mem_req=0 at once, FSM IDLE, req_ready=1, resp_valid never fires.

Source files
------------

// File: rtl/stack_sequencer_pkg.sv
// stack_sequencer_pkg: shared stack-access constants and sequencer state encoding
package stack_sequencer_pkg;
    localparam logic [7:0] DEF_STACK_PAGE = 8'h01;
    localparam int DEF_MAX_BYTES = 3;
    typedef enum logic [2:0] {IDLE, PUSH, PULL_INC, PULL_RD, DONE} state_t;
endpackage

// File: rtl/stack_sequencer.sv
// stack_sequencer: runs one multi-byte push/pull on page 1, pulsing the external SP register
module stack_sequencer
    import stack_sequencer_pkg::*;
#(
    parameter logic [7:0] STACK_PAGE = DEF_STACK_PAGE,
    parameter int MAX_BYTES = DEF_MAX_BYTES
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_pull,
    input  logic [1:0]             req_len,
    input  logic [8*MAX_BYTES-1:0] push_data,
    output logic                   resp_valid,
    output logic [8*MAX_BYTES-1:0] pull_data,
    input  logic [7:0]             sp_cur,
    output logic                   sp_dec,
    output logic                   sp_inc,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [15:0]            mem_addr,
    output logic [7:0]             mem_wdata,
    input  logic [7:0]             mem_rdata,
    input  logic                   mem_ack
);
    state_t state, state_nx;
    logic [1:0] cnt, len_q, cnt_m1, lane;
    logic [8*MAX_BYTES-1:0] data_q;
    assign cnt_m1 = cnt - 2'd1;
    assign lane = len_q - cnt;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (req_valid) state_nx = req_len == 2'd0 ? DONE : req_pull ? PULL_INC : PUSH;
            PUSH:     if (mem_ack && cnt == 2'd1) state_nx = DONE;
            PULL_INC: state_nx = PULL_RD;
            PULL_RD:  if (mem_ack) state_nx = cnt == 2'd1 ? DONE : PULL_INC;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end
    always_comb begin
        req_ready  = state == IDLE;
        resp_valid = state == DONE;
        mem_req    = state == PUSH || state == PULL_RD;
        mem_we     = state == PUSH;
        sp_dec     = state == PUSH && mem_ack;
        sp_inc     = state == PULL_INC;
        mem_addr   = {STACK_PAGE, sp_cur};
        mem_wdata  = state == PUSH ? data_q[{cnt_m1, 3'b000} +: 8] : 8'h00;
    end
    // cnt counts bytes still to move; pushes take the highest remaining byte first
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            len_q     <= '0;
            data_q    <= '0;
            pull_data <= '0;
        end else begin
            if (req_valid && state == IDLE) begin
                cnt    <= req_len;
                len_q  <= req_len;
                data_q <= push_data;
            end
            if (mem_ack && (state == PUSH || state == PULL_RD)) cnt <= cnt_m1;
            if (mem_ack && state == PULL_RD) pull_data[{lane, 3'b000} +: 8] <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_stack_sequencer.sv
// tb_stack_sequencer: SP register + page-1 RAM around the DUT, checked cycle by cycle against a transaction model
module tb_stack_sequencer;
    logic clk = 1'b0;
    logic reset_n, req_valid, req_ready, req_pull, resp_valid;
    logic sp_dec, sp_inc, mem_req, mem_we, mem_ack;
    logic [1:0] req_len;
    logic [23:0] push_data, pull_data;
    logic [7:0] sp, mem_wdata, mem_rdata;
    logic [15:0] mem_addr;
    logic sp_load, fill;
    logic [7:0] sp_val;
    logic [7:0] ram [256];

    stack_sequencer dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_pull(req_pull), .req_len(req_len), .push_data(push_data),
        .resp_valid(resp_valid), .pull_data(pull_data), .sp_cur(sp),
        .sp_dec(sp_dec), .sp_inc(sp_inc), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) sp <= sp_load ? sp_val : sp - {7'd0, sp_dec} + {7'd0, sp_inc};
    always @(posedge clk)
        if (fill) for (int i = 0; i < 256; i++) ram[i] <= 8'(i * 7 + 3);
        else if (mem_req && mem_we && mem_ack) ram[mem_addr[7:0]] <= mem_wdata;
    assign mem_rdata = ram[mem_addr[7:0]];

    typedef struct packed {
        logic req, we, dec, inc, resp, ack, rd;
        logic [7:0] wdata;
    } exp_t;

    exp_t q[$];
    logic [7:0] mmem [256];
    logic [7:0] msp;
    logic [23:0] exp_pd = '0;
    int w[3];
    int cmp_n = 0, err_n = 0, cyc = 0, acc_cyc = 0, last_lat = 0, lane = 0;
    int n_done = 0, dec_n = 0, req_n = 0, resp_n = 0;
    bit go = 0;

    function automatic exp_t mk(bit rq, bit we, bit dc, bit ic, bit rs, bit ak, bit rd, logic [7:0] wd);
        exp_t e;
        e.req = rq; e.we = we; e.dec = dc; e.inc = ic; e.resp = rs; e.ack = ak; e.rd = rd; e.wdata = wd;
        return e;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] ex);
        cmp_n++;
        if (act !== ex) begin
            err_n++;
            $display("FAIL %s: got %0h expected %0h", nm, act, ex);
        end
    endtask

    // One clock: compare at negedge against the expected timeline, advance the model, drive mem_ack
    task automatic tick();
        exp_t e;
        bit busy, nxt;
        logic [7:0] b;
        @(negedge clk);
        cyc++;
        if (!reset_n) begin
            q.delete();
            exp_pd = '0;
        end
        busy = q.size() != 0;
        e = busy ? q[0] : '0;
        if (go) begin
            chk("ctrl", {req_ready, resp_valid, mem_req, mem_we, sp_dec, sp_inc},
                {!busy, e.resp, e.req, e.we, e.dec, e.inc});
            chk("wdata", mem_wdata, e.wdata);
            chk("addr", mem_addr, {8'h01, msp});
            chk("pull_data", pull_data, exp_pd);
        end
        if (sp_dec) dec_n++;
        if (mem_req) req_n++;
        if (resp_valid) begin
            resp_n++;
            last_lat = cyc - acc_cyc;
        end
        if (busy) begin
            if (e.dec) begin
                mmem[msp] = e.wdata;
                msp--;
            end
            if (e.inc) msp++;
            if (e.rd && e.ack) begin
                exp_pd[8*lane +: 8] = mmem[msp];
                lane++;
            end
            if (e.resp) n_done++;
            void'(q.pop_front());
        end
        if (sp_load) msp = sp_val;
        if (fill) for (int i = 0; i < 256; i++) mmem[i] = 8'(i * 7 + 3);
        if (reset_n && !busy && req_valid) begin
            acc_cyc = cyc;
            lane = 0;
            for (int i = 0; i < int'(req_len); i++) begin
                b = req_pull ? 8'h00 : push_data[8*(int'(req_len)-1-i) +: 8];
                if (req_pull) q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 8'h00));
                for (int k = 0; k < w[i]; k++) q.push_back(mk(1, !req_pull, 0, 0, 0, 0, req_pull, b));
                q.push_back(mk(1, !req_pull, !req_pull, 0, 0, 1, req_pull, b));
            end
            q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 8'h00));
        end
        nxt = (q.size() != 0 && q[0].req) ? q[0].ack : 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        mem_ack = nxt;
    endtask

    task automatic setsp(logic [7:0] v);
        sp_load = 1;
        sp_val = v;
        tick();
        sp_load = 0;
    endtask

    task automatic run(bit pull, logic [1:0] len, logic [23:0] d, int w0, int w1, int w2, int busy_at);
        int t = 0;
        int nd = n_done;
        req_valid = 1; req_pull = pull; req_len = len; push_data = d;
        w[0] = w0; w[1] = w1; w[2] = w2;
        tick();
        req_valid = 0; req_pull = 1'($urandom); req_len = 2'($urandom); push_data = 24'($urandom);
        while (n_done == nd && t < 300) begin
            req_valid = t == busy_at;
            tick();
            t++;
        end
        req_valid = 0;
        chk("timeout", n_done != nd, 1);
    endtask

    initial begin
        int d0, r0, s0;
        logic [23:0] pd;
        reset_n = 0; req_valid = 0; req_pull = 0; req_len = 0; push_data = 0; mem_ack = 0;
        sp_load = 1; sp_val = 8'hFD; fill = 1;
        tick();
        sp_load = 0; fill = 0; go = 1;
        tick();
        chk("rst_ready", req_ready, 1);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_pull_data", pull_data, 0);
        reset_n = 1;
        tick();
        // JSR-style push
        run(0, 2, 24'h001234, 0, 0, 0, -1);
        chk("t1_ram_fd", ram[8'hFD], 8'h12);
        chk("t1_ram_fc", ram[8'hFC], 8'h34);
        chk("t1_sp", sp, 8'hFB);
        chk("t1_lat", last_lat, 3);
        // RTI-style pull of bytes laid down by a 3-byte push
        setsp(8'hFD);
        run(0, 3, 24'h123420, 0, 0, 0, -1);
        chk("t2_ram_fb", ram[8'hFB], 8'h20);
        chk("t2_sp_pre", sp, 8'hFA);
        run(1, 3, 24'h0, 0, 0, 0, -1);
        chk("t2_pull_data", pull_data, 24'h123420);
        chk("t2_model_pd", exp_pd, 24'h123420);
        chk("t2_sp", sp, 8'hFD);
        chk("t2_lat", last_lat, 7);
        // SP wrap across 00/FF
        setsp(8'h00);
        run(0, 1, 24'h0000AA, 0, 0, 0, -1);
        chk("t3_ram_00", ram[8'h00], 8'hAA);
        chk("t3_sp_push", sp, 8'hFF);
        run(1, 1, 24'h0, 0, 0, 0, -1);
        pd = pull_data;
        chk("t3_sp_pull", sp, 8'h00);
        chk("t3_lane0", pd[7:0], 8'hAA);
        chk("t3_pull_data", pd, 24'h1234AA);
        // Wait states
        setsp(8'h80);
        d0 = dec_n;
        run(0, 2, 24'h00BEEF, 3, 3, 0, -1);
        chk("t4_dec_pulses", dec_n - d0, 2);
        chk("t4_lat", last_lat, 9);
        chk("t4_ram_80", ram[8'h80], 8'hBE);
        chk("t4_ram_7f", ram[8'h7F], 8'hEF);
        // Request while busy, then a zero-length request
        run(1, 3, 24'h0, 0, 0, 0, 1);
        chk("t5_pull_data", pull_data, 24'h8ABEEF);
        chk("t5_sp", sp, 8'h81);
        chk("t5_lat", last_lat, 7);
        r0 = req_n;
        run(0, 0, 24'hFFFFFF, 0, 0, 0, -1);
        chk("t5_len0_lat", last_lat, 1);
        chk("t5_len0_mem_req", req_n - r0, 0);
        chk("t5_len0_sp", sp, 8'h81);
        // Reset after the first pushed byte
        setsp(8'h40);
        s0 = resp_n;
        req_valid = 1; req_pull = 0; req_len = 3; push_data = 24'h563412;
        w[0] = 0; w[1] = 2; w[2] = 2;
        tick();
        req_valid = 0;
        tick();
        reset_n = 0;
        tick();
        chk("t6_mem_req", mem_req, 0);
        chk("t6_ready", req_ready, 1);
        tick();
        reset_n = 1;
        repeat (4) tick();
        chk("t6_no_resp", resp_n - s0, 0);
        chk("t6_sp", sp, 8'h3F);
        chk("t6_ram_40", ram[8'h40], 8'h56);
        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 7) == 0) setsp(8'($urandom));
            run(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 24'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 1) == 1 ? 0 : -1);
            repeat ($urandom_range(0, 2)) tick();
        end
        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end
endmodule
